mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port synchronous memory between instruction fetch and the load/store path driven by the controller's memory_en/store_size outputs.
- Issues one memory access at a time, generates byte write-enables and lane-replicated write data from store_size, and returns read data with a valid pulse.
- Data requests have priority over fetch. A starvation counter guarantees fetch progress.
- Sits between core datapath and memory; load sign/zero extension is done downstream, not here.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, memory word width (fixed 32; four byte lanes)
STARVE_LIM, 4, consecutive data grants with fetch pending before fetch is forced

Ports:
CLK  in  1  clock, all state on rising edge
RST_N  in  1  asynchronous active-low reset
fetch_req  in  1  fetch request, held until fetch_valid
fetch_addr  in  ADDR_W  fetch byte address (word aligned)
fetch_rdata  out  32  fetched word, valid with fetch_valid
fetch_valid  out  1  one-cycle completion pulse for fetch
data_req  in  1  load/store request (memory_en), held until data_valid
data_addr  in  ADDR_W  load/store byte address
data_wdata  in  32  store data, low-order bytes significant
store_size  in  2  00 byte, 01 half, 10 word, 11 load
data_rdata  out  32  raw loaded word
data_valid  out  1  one-cycle completion pulse (load data or store ack)
misalign_err  out  1  pulses with data_valid for a rejected misaligned store
mem_addr  out  ADDR_W  word address to memory, bits [1:0] forced 0
mem_wdata  out  32  lane-replicated write data
mem_we  out  4  byte write enables
mem_re  out  1  read strobe; memory returns mem_rdata next cycle
mem_rdata  in  32  memory read data, 1-cycle latency

Behaviour:
- Reset (RST_N low, async): state IDLE; starvation counter 0. All outputs 0: fetch_valid, data_valid, misalign_err, mem_re, mem_we, mem_addr, mem_wdata, fetch_rdata, data_rdata. In-flight access is abandoned and its return data discarded.
- FSM states: IDLE, FETCH_WAIT, LOAD_WAIT, STORE_ACK.
- IDLE arbitration, evaluated each cycle in this order:
  - If fetch_req and counter==STARVE_LIM: grant fetch.
  - Else if data_req: grant data.
  - Else if fetch_req: grant fetch.
  - Else stay in IDLE.
- Fetch grant: mem_re=1, mem_addr=fetch_addr with [1:0] zeroed. Go to FETCH_WAIT. Counter clears to 0.
- Load grant (store_size==11): mem_re=1, mem_addr=data_addr. Go to LOAD_WAIT. Counter increments, saturating at STARVE_LIM, only if fetch_req is high; otherwise it clears.
- Store grant: aligned store drives mem_we/mem_wdata for exactly one cycle, then goes to STORE_ACK. Misaligned store (half with addr[0]=1; word with addr[1:0]!=0) issues no write and goes to STORE_ACK with an error flag set. Counter updates as for a load.
- FETCH_WAIT: register mem_rdata into fetch_rdata, pulse fetch_valid for 1 cycle, return to IDLE.
- LOAD_WAIT: register mem_rdata into data_rdata, pulse data_valid, return to IDLE.
- STORE_ACK: pulse data_valid, plus misalign_err if the flag is set. Return to IDLE.
- Latency: access issued in cycle N; valid asserts in cycle N+2 (registered). The next issue can occur in cycle N+2. Throughput is one access per 2 cycles.
- mem_re and mem_we are never high in the same cycle. Outside the grant cycle, mem_re=0 and mem_we=0.
- Byte lanes:
  - SB: mem_we=0001<<addr[1:0]; mem_wdata={4{wdata[7:0]}}.
  - SH: mem_we=0011<<{addr[1],1'b0}; mem_wdata={2{wdata[15:0]}}.
  - SW: mem_we=1111; mem_wdata=wdata.
- Request dropped mid-transaction: the access still completes and the valid still pulses. Requesters must ignore it.
- Simultaneous fetch_req and data_req with counter<STARVE_LIM: data wins and fetch waits.
- fetch_rdata and data_rdata hold their value until overwritten by the next completion.

Decomposition:
- Shared package mem_pkg:
  - state enum.
  - store_size encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_LOAD).
  - function returning byte enables and replicated write data from size and addr[1:0].
- One sub-module is natural: store_lane_gen (combinational: size, addr[1:0], wdata -> we, wdata_rep, misaligned).

Test Plan:
- Reset mid-LOAD_WAIT: assert RST_N=0 one cycle after a load issue -> all outputs 0 immediately; no data_valid afterwards; state IDLE.
- Load at 0x0000_0104, mem_rdata=0xDEADBEEF -> mem_re=1 with mem_addr=0x104 at N; data_valid=1 and data_rdata=0xDEADBEEF at N+2.
- SB addr 0x...03, wdata 0x000000A5 -> mem_we=1000, mem_wdata=0xA5A5A5A5 for one cycle; data_valid at N+2.
- SH addr 0x...02, wdata 0x1234 -> mem_we=1100, mem_wdata=0x12341234. SW addr 0x...01 -> mem_we=0000 throughout; data_valid=1 and misalign_err=1 at N+2.
- fetch_req and data_req both held high, STARVE_LIM=4 -> exactly 4 data grants, then 1 fetch grant; pattern repeats; fetch_valid never starved.
- fetch_req only, continuous -> mem_re every other cycle; fetch_valid pulses at N+2, N+4, …; counter stays 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
//==============================================================================
// Module   : mem_pkg
// Purpose  : Shared types, store-size encodings and byte-lane helper for
//            the instruction/data memory arbiter.
// Revision : 1.0
//==============================================================================
package mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_FETCH_WAIT = 2'd1,
      ST_LOAD_WAIT  = 2'd2,
      ST_STORE_ACK  = 2'd3
   } state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_LOAD = 2'b11;

   typedef struct packed {
      logic [3:0]  we;
      logic [31:0] wdata;
      logic        misaligned;
   } lane_t;

   // Store data is replicated across every lane so the enable mask alone
   // selects which bytes land in memory.
   function automatic lane_t lane_gen(
      input logic [1:0]  size,
      input logic [1:0]  addr_lo,
      input logic [31:0] wdata
   );
      lane_t l;
      l.we         = 4'b0000;
      l.wdata      = 32'h0000_0000;
      l.misaligned = 1'b0;
      case (size)
         SZ_BYTE: begin
            l.we    = 4'b0001 << addr_lo;
            l.wdata = {4{wdata[7:0]}};
         end
         SZ_HALF: begin
            l.wdata = {2{wdata[15:0]}};
            if (addr_lo[0]) begin
               l.misaligned = 1'b1;
            end else begin
               l.we = 4'b0011 << {addr_lo[1], 1'b0};
            end
         end
         SZ_WORD: begin
            l.wdata = wdata;
            if (addr_lo != 2'b00) begin
               l.misaligned = 1'b1;
            end else begin
               l.we = 4'b1111;
            end
         end
         default: begin
            l.we = 4'b0000;
         end
      endcase
      return l;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
//==============================================================================
// Module   : mem_arbiter_if
// Purpose  : Fetch, load/store and memory-side signals of the arbiter.
// Revision : 1.0
//==============================================================================
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              fetch_req;
   logic [ADDR_W-1:0] fetch_addr;
   logic [DATA_W-1:0] fetch_rdata;
   logic              fetch_valid;

   logic              data_req;
   logic [ADDR_W-1:0] data_addr;
   logic [DATA_W-1:0] data_wdata;
   logic [1:0]        store_size;
   logic [DATA_W-1:0] data_rdata;
   logic              data_valid;
   logic              misalign_err;

   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [3:0]        mem_we;
   logic              mem_re;
   logic [DATA_W-1:0] mem_rdata;

   // Arbiter side
   modport slave (
      input  fetch_req, fetch_addr, data_req, data_addr, data_wdata,
             store_size, mem_rdata,
      output fetch_rdata, fetch_valid, data_rdata, data_valid, misalign_err,
             mem_addr, mem_wdata, mem_we, mem_re
   );

   // Core and memory side
   modport master (
      output fetch_req, fetch_addr, data_req, data_addr, data_wdata,
             store_size, mem_rdata,
      input  fetch_rdata, fetch_valid, data_rdata, data_valid, misalign_err,
             mem_addr, mem_wdata, mem_we, mem_re
   );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter_store_lane_gen.sv
`default_nettype none
//==============================================================================
// Module   : store_lane_gen
// Purpose  : Byte enables, replicated write data and misalignment flag.
// Revision : 1.0
//==============================================================================
module store_lane_gen
   import mem_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_wdata,
   output logic [3:0]  o_we,
   output logic [31:0] o_wdata_rep,
   output logic        o_misaligned
);

   lane_t w_lane;

   always_comb begin
      w_lane = lane_gen(i_size, i_addr_lo, i_wdata);
   end

   assign o_we         = w_lane.we;
   assign o_wdata_rep  = w_lane.wdata;
   assign o_misaligned = w_lane.misaligned;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : mem_arbiter
// Purpose  : Single-port memory arbiter, data over fetch with starvation guard.
// Revision : 1.0
//==============================================================================
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_LIM = 4
) (
   input  logic          CLK,
   input  logic          RST_N,
   mem_arbiter_if.slave  bus
);

   localparam int                 c_cnt_w = $clog2(STARVE_LIM + 1);
   localparam logic [c_cnt_w-1:0] c_lim   = c_cnt_w'(STARVE_LIM);

   state_t              r_state;
   state_t              w_state_next;
   logic [c_cnt_w-1:0]  r_starve_cnt;
   logic                r_err_flag;
   logic                r_fetch_valid;
   logic                r_data_valid;
   logic                r_misalign_err;
   logic [DATA_W-1:0]   r_fetch_rdata;
   logic [DATA_W-1:0]   r_data_rdata;

   logic                w_grant_fetch;
   logic                w_grant_data;
   logic                w_is_load;
   logic                w_mem_re;
   logic [3:0]          w_mem_we;
   logic [ADDR_W-1:0]   w_mem_addr;
   logic [DATA_W-1:0]   w_mem_wdata;
   logic [3:0]          w_lane_we;
   logic [31:0]         w_lane_wdata;
   logic                w_lane_misaligned;
   logic                w_unused;

   assign w_is_load = (bus.store_size == SZ_LOAD);
   assign w_unused  = &{1'b0, bus.fetch_addr[1:0]};

   store_lane_gen u_lane (
      .i_size       (bus.store_size),
      .i_addr_lo    (bus.data_addr[1:0]),
      .i_wdata      (bus.data_wdata),
      .o_we         (w_lane_we),
      .o_wdata_rep  (w_lane_wdata),
      .o_misaligned (w_lane_misaligned)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Grants are gated by RST_N so no strobe can escape while reset is held.
   always_comb begin
      w_state_next  = r_state;
      w_grant_fetch = 1'b0;
      w_grant_data  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (RST_N) begin
               if (bus.fetch_req && (r_starve_cnt == c_lim)) begin
                  w_grant_fetch = 1'b1;
               end else if (bus.data_req) begin
                  w_grant_data = 1'b1;
               end else if (bus.fetch_req) begin
                  w_grant_fetch = 1'b1;
               end
            end
            if (w_grant_fetch) begin
               w_state_next = ST_FETCH_WAIT;
            end else if (w_grant_data) begin
               w_state_next = w_is_load ? ST_LOAD_WAIT : ST_STORE_ACK;
            end
         end
         ST_FETCH_WAIT: w_state_next = ST_IDLE;
         ST_LOAD_WAIT:  w_state_next = ST_IDLE;
         ST_STORE_ACK:  w_state_next = ST_IDLE;
         default:       w_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_mem_re    = 1'b0;
      w_mem_we    = 4'b0000;
      w_mem_addr  = '0;
      w_mem_wdata = '0;
      if (w_grant_fetch) begin
         w_mem_re   = 1'b1;
         w_mem_addr = {bus.fetch_addr[ADDR_W-1:2], 2'b00};
      end else if (w_grant_data) begin
         w_mem_addr = {bus.data_addr[ADDR_W-1:2], 2'b00};
         if (w_is_load) begin
            w_mem_re = 1'b1;
         end else if (!w_lane_misaligned) begin
            w_mem_we    = w_lane_we;
            w_mem_wdata = w_lane_wdata;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_starve_cnt   <= '0;
         r_err_flag     <= 1'b0;
         r_fetch_valid  <= 1'b0;
         r_data_valid   <= 1'b0;
         r_misalign_err <= 1'b0;
         r_fetch_rdata  <= '0;
         r_data_rdata   <= '0;
      end else begin
         r_fetch_valid  <= (r_state == ST_FETCH_WAIT);
         r_data_valid   <= (r_state == ST_LOAD_WAIT) || (r_state == ST_STORE_ACK);
         r_misalign_err <= (r_state == ST_STORE_ACK) && r_err_flag;
         if (r_state == ST_FETCH_WAIT) begin
            r_fetch_rdata <= bus.mem_rdata;
         end
         if (r_state == ST_LOAD_WAIT) begin
            r_data_rdata <= bus.mem_rdata;
         end
         // Count only data grants that made a pending fetch wait.
         if (w_grant_fetch) begin
            r_starve_cnt <= '0;
         end else if (w_grant_data) begin
            if (!bus.fetch_req) begin
               r_starve_cnt <= '0;
            end else if (r_starve_cnt != c_lim) begin
               r_starve_cnt <= r_starve_cnt + c_cnt_w'(1);
            end
            r_err_flag <= !w_is_load && w_lane_misaligned;
         end
      end
   end

   assign bus.mem_re       = w_mem_re;
   assign bus.mem_we       = w_mem_we;
   assign bus.mem_addr     = w_mem_addr;
   assign bus.mem_wdata    = w_mem_wdata;
   assign bus.fetch_valid  = r_fetch_valid;
   assign bus.fetch_rdata  = r_fetch_rdata;
   assign bus.data_valid   = r_data_valid;
   assign bus.data_rdata   = r_data_rdata;
   assign bus.misalign_err = r_misalign_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed self-checking bench for mem_arbiter.
// Revision : 1.0
//==============================================================================
module tb_mem_arbiter;
   import mem_pkg::*;

   logic CLK = 1'b0;
   logic RST_N;
   int   n_chk  = 0;
   int   n_pass = 0;

   always #5 CLK = ~CLK;

   mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIM(4)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   function automatic logic [31:0] mem_model(input logic [31:0] a);
      return (a == 32'h0000_0104) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000);
   endfunction

   always @(posedge CLK) begin
      if (bus.mem_re) bus.mem_rdata <= mem_model(bus.mem_addr);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic clr();
      bus.fetch_req  = 1'b0;
      bus.fetch_addr = 32'h0;
      bus.data_req   = 1'b0;
      bus.data_addr  = 32'h0;
      bus.data_wdata = 32'h0;
      bus.store_size = SZ_LOAD;
   endtask

   task automatic data_op(input string tag, input logic [1:0] sz, input logic [31:0] addr,
                          input logic [31:0] wd, input logic exp_re, input logic [3:0] exp_we,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                          input logic exp_err);
      @(negedge CLK);
      bus.data_req = 1'b1; bus.store_size = sz; bus.data_addr = addr; bus.data_wdata = wd;
      #1;
      check({tag, " re"}, bus.mem_re, exp_re);
      check({tag, " we"}, bus.mem_we, exp_we);
      check({tag, " addr"}, bus.mem_addr, {addr[31:2], 2'b00});
      check({tag, " dv idle"}, bus.data_valid, 1'b0);
      if (exp_we != 4'b0000) check({tag, " wdata"}, bus.mem_wdata, exp_wdata);
      @(negedge CLK);
      bus.data_req = 1'b0;
      #1;
      check({tag, " we n+1"}, bus.mem_we, 4'b0000);
      check({tag, " dv n+1"}, bus.data_valid, 1'b0);
      @(negedge CLK);
      #1;
      check({tag, " dv n+2"}, bus.data_valid, 1'b1);
      check({tag, " err n+2"}, bus.misalign_err, exp_err);
      if (sz == SZ_LOAD) check({tag, " rdata"}, bus.data_rdata, exp_rdata);
   endtask

   initial begin
      int g;
      int nfv;
      clr();
      RST_N = 1'b0;
      bus.fetch_req  = 1'b1;
      bus.data_req   = 1'b1;
      bus.store_size = SZ_WORD;
      bus.data_wdata = 32'hFFFF_FFFF;
      repeat (2) @(negedge CLK);
      #1;
      check("rst mem_re", bus.mem_re, 1'b0);
      check("rst mem_we", bus.mem_we, 4'b0000);
      check("rst mem_addr", bus.mem_addr, 32'h0);
      check("rst mem_wdata", bus.mem_wdata, 32'h0);
      check("rst valids", {bus.fetch_valid, bus.data_valid, bus.misalign_err}, 3'b000);
      check("rst rdata", bus.fetch_rdata | bus.data_rdata, 32'h0);
      @(negedge CLK);
      clr();
      RST_N = 1'b1;

      data_op("ld104", SZ_LOAD, 32'h0000_0104, 32'h0, 1'b1, 4'b0000, 32'h0, 32'hDEAD_BEEF, 1'b0);
      data_op("sb103", SZ_BYTE, 32'h0000_0103, 32'h0000_00A5, 1'b0, 4'b1000, 32'hA5A5_A5A5, 32'h0, 1'b0);
      data_op("sh102", SZ_HALF, 32'h0000_0102, 32'h0000_1234, 1'b0, 4'b1100, 32'h1234_1234, 32'h0, 1'b0);
      data_op("sh100", SZ_HALF, 32'h0000_0100, 32'h0000_BEEF, 1'b0, 4'b0011, 32'hBEEF_BEEF, 32'h0, 1'b0);
      data_op("sw101", SZ_WORD, 32'h0000_0101, 32'h1111_2222, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
      data_op("sw200", SZ_WORD, 32'h0000_0200, 32'hCAFE_F00D, 1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0);
      check("data_rdata hold", bus.data_rdata, 32'hDEAD_BEEF);

      // Single fetch with unaligned low bits
      @(negedge CLK);
      check("err cleared", bus.misalign_err, 1'b0);
      bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0000_030B;
      #1;
      check("f30b re", bus.mem_re, 1'b1);
      check("f30b addr", bus.mem_addr, 32'h0000_0308);
      @(negedge CLK);
      bus.fetch_req = 1'b0;
      #1;
      check("f30b fv n+1", bus.fetch_valid, 1'b0);
      @(negedge CLK);
      #1;
      check("f30b fv n+2", bus.fetch_valid, 1'b1);
      check("f30b rdata", bus.fetch_rdata, 32'h5A5A_0308);
      check("f30b dv", bus.data_valid, 1'b0);

      // Continuous fetch only
      @(negedge CLK);
      bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0000_0080;
      for (int k = 0; k < 10; k++) begin
         if (k > 0) @(negedge CLK);
         #1;
         check($sformatf("fonly re%0d", k), bus.mem_re, (k % 2 == 0));
         check($sformatf("fonly fv%0d", k), bus.fetch_valid, (k >= 2) && (k % 2 == 0));
      end
      @(negedge CLK);
      clr();
      repeat (2) @(negedge CLK);
      #1;
      check("fonly rdata", bus.fetch_rdata, 32'h5A5A_0080);

      // Both held: four data grants then one fetch, repeating
      @(negedge CLK);
      bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0000_0040;
      bus.data_req = 1'b1; bus.store_size = SZ_LOAD; bus.data_addr = 32'h0000_0104;
      g = 0; nfv = 0;
      for (int k = 0; k < 22; k++) begin
         if (k > 0) @(negedge CLK);
         #1;
         if (bus.fetch_valid) nfv++;
         if (bus.mem_re) begin
            check($sformatf("starve grant%0d", g), bus.mem_addr,
                  (g % 5 == 4) ? 32'h0000_0040 : 32'h0000_0104);
            g++;
         end
      end
      check("starve grants", g, 11);
      check("starve fetch_valid", nfv, 2);
      @(negedge CLK);
      clr();
      repeat (3) @(negedge CLK);

      // Reset while a load is outstanding
      @(negedge CLK);
      bus.data_req = 1'b1; bus.store_size = SZ_LOAD; bus.data_addr = 32'h0000_0104;
      #1;
      check("rl issue", bus.mem_re, 1'b1);
      @(negedge CLK);
      bus.data_req = 1'b0;
      RST_N = 1'b0;
      #1;
      check("rl dv", bus.data_valid, 1'b0);
      check("rl rdata", bus.data_rdata, 32'h0);
      check("rl frdata", bus.fetch_rdata, 32'h0);
      check("rl strobes", {bus.mem_re, bus.mem_we}, 5'b00000);
      check("rl mem_addr", bus.mem_addr, 32'h0);
      @(negedge CLK);
      RST_N = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         #1;
         check($sformatf("rl no dv%0d", k), bus.data_valid, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
